// File: rtl/fifo_rd_drain.sv
// Read-side drain for the dual-clock FIFO: 1-cycle-latency read port -> 2-entry buffer -> framed valid/ready stream.
// Optional statistics (rd_count, err_spur) are built only when FIFO_RD_DRAIN_STATS_EN is defined.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int BEAT_W     = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  r_empty,
  input  logic                  r_valid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           rd_count,
  output logic                  err_spur
);

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  function automatic logic [BEAT_W-1:0] beat_next(input logic [BEAT_W-1:0] b);
    return (b == BEAT_MAX) ? '0 : b + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [1:0]            occ;
  logic                  inflight_p1;
  logic [BEAT_W-1:0]     beat;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [DATA_WIDTH-1:0] buf_q [2];

  logic       pop;
  logic       capture;
  logic [2:0] occ_sum;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_q[rd_ptr];
  assign m_last  = m_valid & (beat == BEAT_MAX);
  assign pop     = m_valid & m_ready;
  assign capture = r_valid & inflight_p1;

  // Words already committed to the buffer after this cycle's pop; a new request is safe only below 2.
  assign occ_sum = {1'b0, occ} + {2'b00, inflight_p1} - {2'b00, pop};
  assign r_en    = r_rst_n & ~r_empty & (occ_sum < 3'd2);

  // Stage p0 -> p1: request issued, FIFO returns the word one cycle later.
  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      occ         <= 2'd0;
      inflight_p1 <= 1'b0;
      beat        <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      inflight_p1 <= r_en;
      if (capture) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        beat   <= beat_next(beat);
      end
      case ({capture, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Stage p1 -> buffer: data storage carries no reset.
  always_ff @(posedge r_clk) begin
    if (capture) buf_q[wr_ptr] <= r_data;
  end

`ifdef FIFO_RD_DRAIN_STATS_EN
  logic [15:0] rd_count_q;
  logic        err_spur_q;

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      rd_count_q <= 16'd0;
      err_spur_q <= 1'b0;
    end else begin
      if (pop) rd_count_q <= sat_inc16(rd_count_q);
      if (r_valid && !inflight_p1) err_spur_q <= 1'b1;
    end
  end

  assign rd_count = rd_count_q;
  assign err_spur = err_spur_q;
`else
  assign rd_count = 16'd0;
  assign err_spur = 1'b0;
`endif

endmodule
